udp_tx_packetizer: RTL

UDP_TX_PACKETIZER -- requirements
Module: udp_tx_packetizer

---
 rtl/udp_pkg.sv | 25 ++
 rtl/udp_byte_fifo.sv | 59 +++++
 rtl/udp_tx_packetizer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// Shared state encoding, header constants and header byte helper for the UDP TX packetizer.
package udp_pkg;

    localparam int unsigned HDR_LEN = 4;
    localparam int unsigned LEN_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GAP   = 2'd3
    } pkt_state_e;

    // Header byte order: sequence high, sequence low, payload length high, payload length low.
    function automatic logic [7:0] hdr_byte(input logic [15:0] seq, input logic [15:0] plen,
                                            input logic [1:0] idx);
        case (idx)
            2'd0:    return seq[15:8];
            2'd1:    return seq[7:0];
            2'd2:    return plen[15:8];
            default: return plen[7:0];
        endcase
    endfunction

endpackage

// File: rtl/udp_byte_fifo.sv
// Synchronous single-clock byte FIFO with occupancy count, registered write-ready and
// registered read data (zero when no pop happens).
module udp_byte_fifo #(
    parameter int unsigned DEPTH = 2048
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] count_nx;

    assign push = wr_en & wr_ready;
    assign pop  = rd_en & (count != '0);

    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nx = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_ready <= 1'b0;
            rd_data  <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_nx;
            wr_ready <= (count_nx != CNT_W'(DEPTH));
            rd_data  <= pop ? mem[rd_ptr] : 8'h00;
        end
    end

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/udp_tx_packetizer.sv
// Buffers a byte stream and hands it to a UDP sender in packets of up to MAX_LEN bytes.
// Optional build macro UDP_TX_SEQ_HDR_EN prefixes each packet with a 4-byte sequence/length header.
module udp_tx_packetizer
    import udp_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned MAX_LEN    = 1024,
    parameter int unsigned TIMEOUT    = 125000,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic             rgmii_clk,
    input  logic             rstn,
    input  logic             src_valid,
    input  logic [7:0]       src_data,
    output logic             src_ready,
    output logic             send_en,
    input  logic             send_fifo_en,
    output logic [7:0]       send_fifo_data,
    output logic             send_fifo_empty,
    output logic [LEN_W-1:0] udp_send_data_length,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT) + 1;
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES) + 1;
`ifdef UDP_TX_SEQ_HDR_EN
    localparam int unsigned PAY_MAX = MAX_LEN - HDR_LEN;
    localparam logic [LEN_W-1:0] HDR_B = LEN_W'(HDR_LEN);
`else
    localparam int unsigned PAY_MAX = MAX_LEN;
    localparam logic [LEN_W-1:0] HDR_B = '0;
`endif

    pkt_state_e       state, state_nx;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       fifo_rd_data;
    logic [LEN_W-1:0] avail_c;
    logic [LEN_W-1:0] take_c;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nx;
    logic [LEN_W-1:0] pkt_len, pkt_len_nx;
    logic [LEN_W-1:0] remaining, remaining_nx;
    logic             fire_c;
    logic             pop_c;
`ifdef UDP_TX_SEQ_HDR_EN
    logic [15:0]      seq, seq_nx;
    logic [7:0]       hdr_c, hdr_q;
`endif

    udp_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (rgmii_clk),
        .rstn     (rstn),
        .wr_en    (src_valid),
        .wr_data  (src_data),
        .wr_ready (src_ready),
        .rd_en    (pop_c),
        .rd_data  (fifo_rd_data),
        .count    (fifo_count)
    );

    assign avail_c = LEN_W'(fifo_count);
    assign take_c  = (avail_c >= LEN_W'(PAY_MAX)) ? LEN_W'(PAY_MAX) : avail_c;

    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            state                <= ST_IDLE;
            to_cnt               <= '0;
            gap_cnt              <= '0;
            pkt_len              <= '0;
            remaining            <= '0;
            send_en              <= 1'b0;
            send_fifo_empty      <= 1'b1;
            busy                 <= 1'b0;
            udp_send_data_length <= '0;
        end else begin
            state                <= state_nx;
            to_cnt               <= to_cnt_nx;
            gap_cnt              <= gap_cnt_nx;
            pkt_len              <= pkt_len_nx;
            remaining            <= remaining_nx;
            send_en              <= (state_nx == ST_ARM) || (state_nx == ST_DRAIN);
            send_fifo_empty      <= !((state_nx == ST_ARM) || (state_nx == ST_DRAIN));
            busy                 <= (state_nx != ST_IDLE);
            udp_send_data_length <= (pkt_len_nx == '0) ? '0 : pkt_len_nx + HDR_B;
        end
    end

    always_comb begin
        state_nx     = state;
        to_cnt_nx    = to_cnt;
        gap_cnt_nx   = gap_cnt;
        pkt_len_nx   = pkt_len;
        remaining_nx = remaining;
        pop_c        = 1'b0;
        fire_c       = send_fifo_en && ((state == ST_ARM) || (state == ST_DRAIN)) &&
                       (remaining != '0);
`ifdef UDP_TX_SEQ_HDR_EN
        seq_nx       = seq;
        hdr_c        = 8'h00;
`endif
        case (state)
            ST_IDLE: begin
                to_cnt_nx = (avail_c == '0) ? '0 : to_cnt + TO_W'(1);
                if ((avail_c >= LEN_W'(PAY_MAX)) ||
                    ((avail_c != '0) && (to_cnt == TO_W'(TIMEOUT - 1)))) begin
                    state_nx     = ST_ARM;
                    to_cnt_nx    = '0;
                    pkt_len_nx   = take_c;
                    remaining_nx = take_c + HDR_B;
                end
            end
            ST_ARM, ST_DRAIN: begin
                if (fire_c) begin
                    remaining_nx = remaining - LEN_W'(1);
                    state_nx     = (remaining == LEN_W'(1)) ? ST_GAP : ST_DRAIN;
`ifdef UDP_TX_SEQ_HDR_EN
                    if (remaining == LEN_W'(1)) seq_nx = seq + 16'd1;
`endif
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    state_nx   = ST_IDLE;
                    gap_cnt_nx = '0;
                    pkt_len_nx = '0;
                end else begin
                    gap_cnt_nx = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
`ifdef UDP_TX_SEQ_HDR_EN
        // Header bytes are sent while more than the payload is still outstanding.
        if (fire_c && (remaining > pkt_len)) begin
            hdr_c = hdr_byte(seq, pkt_len, 2'(pkt_len + HDR_B - remaining));
        end else begin
            pop_c = fire_c;
        end
`else
        pop_c = fire_c;
`endif
    end

`ifdef UDP_TX_SEQ_HDR_EN
    always_ff @(posedge rgmii_clk) begin
        if (!rstn) begin
            seq   <= '0;
            hdr_q <= 8'h00;
        end else begin
            seq   <= seq_nx;
            hdr_q <= hdr_c;
        end
    end

    // FIFO read data is zero whenever no payload byte was popped, so OR-merge is safe.
    assign send_fifo_data = fifo_rd_data | hdr_q;
`else
    assign send_fifo_data = fifo_rd_data;
`endif

endmodule
